// File: rtl/r5_fft_pkg.sv
// Shared constants, phase encoding and a width helper for the radix-5 SDF FFT stages.
package r5_fft_pkg;

  localparam int RADIX       = 5;
  localparam int FILL_PHASES = 4;

  typedef enum logic [2:0] {
    PH_0 = 3'd0,
    PH_1 = 3'd1,
    PH_2 = 3'd2,
    PH_3 = 3'd3,
    PH_4 = 3'd4
  } phase_e;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/r5_sdf_ctrl_mod_cnt.sv
// Modulo-MOD counter with enable, synchronous clear and a combinational wrap pulse for chaining.
module mod_cnt
  import r5_fft_pkg::*;
#(
  parameter int MOD = 5,
  parameter int W   = clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_wrap = i_en & (r_cnt == W'(MOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/r5_sdf_ctrl.sv
// Sequencer for one radix-5 single-delay-feedback FFT stage: fill phases 0..3, butterfly
// in phase 4, drain legs 1..4 during the next frame's fill. Outputs describe the sample just accepted.
module r5_sdf_ctrl
  import r5_fft_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int N_FFT = 45,
  parameter int TW_AW = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sync_clr,
  input  logic             i_in_valid,
  output logic             o_shift_en,
  output logic [1:0]       o_wr_sel,
  output logic             o_bf_en,
  output logic [2:0]       o_out_sel,
  output logic [TW_AW-1:0] o_tw_addr,
  output logic             o_out_valid,
  output logic             o_frame_last,
  output logic [2:0]       o_phase
);

  localparam int IDX_W = clog2(DEPTH);

  logic             w_accept;
  logic [IDX_W-1:0] w_idx;
  logic             w_idx_wrap;
  logic [2:0]       w_phase_cnt;
  logic             w_phase_wrap;
  phase_e           w_phase;
  logic             w_is_ph4;
  logic [1:0]       w_wr_sel_next;
  logic [2:0]       w_out_sel_next;
  logic [TW_AW-1:0] w_tw_next;
  logic             w_last_next;

  logic             r_shift_en;
  logic [1:0]       r_wr_sel;
  logic             r_bf_en;
  logic [2:0]       r_out_sel;
  logic [TW_AW-1:0] r_tw_addr;
  logic             r_out_valid;
  logic             r_frame_last;
  logic [2:0]       r_phase;
  logic             r_primed;

  // sync_clr discards the sample presented alongside it.
  assign w_accept = i_in_valid & ~i_sync_clr;

  mod_cnt #(.MOD(DEPTH), .W(IDX_W)) u_idx_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_accept),
    .i_clr  (i_sync_clr),
    .o_cnt  (w_idx),
    .o_wrap (w_idx_wrap)
  );

  mod_cnt #(.MOD(RADIX), .W(3)) u_phase_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_idx_wrap),
    .i_clr  (i_sync_clr),
    .o_cnt  (w_phase_cnt),
    .o_wrap (w_phase_wrap)
  );

  assign w_phase        = phase_e'(w_phase_cnt);
  assign w_is_ph4       = (w_phase == PH_4);
  assign w_wr_sel_next  = w_is_ph4 ? 2'd0 : w_phase_cnt[1:0];
  assign w_out_sel_next = w_is_ph4 ? 3'd0 : w_phase_cnt + 3'd1;
  // N_FFT >= 4*(DEPTH-1)+1 keeps the product below N_FFT, so no modulo stage.
  assign w_tw_next      = TW_AW'(w_out_sel_next) * TW_AW'(w_idx);
  assign w_last_next    = w_is_ph4 & (w_idx == IDX_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift_en   <= 1'b0;
      r_wr_sel     <= '0;
      r_bf_en      <= 1'b0;
      r_out_sel    <= '0;
      r_tw_addr    <= '0;
      r_out_valid  <= 1'b0;
      r_frame_last <= 1'b0;
      r_phase      <= '0;
      r_primed     <= 1'b0;
    end else if (i_sync_clr) begin
      r_shift_en   <= 1'b0;
      r_wr_sel     <= '0;
      r_bf_en      <= 1'b0;
      r_out_sel    <= '0;
      r_tw_addr    <= '0;
      r_out_valid  <= 1'b0;
      r_frame_last <= 1'b0;
      r_phase      <= '0;
      r_primed     <= 1'b0;
    end else if (w_accept) begin
      r_shift_en   <= 1'b1;
      r_wr_sel     <= w_wr_sel_next;
      r_bf_en      <= w_is_ph4;
      r_out_sel    <= w_out_sel_next;
      r_tw_addr    <= w_tw_next;
      r_out_valid  <= w_is_ph4 | r_primed;
      r_frame_last <= w_last_next;
      r_phase      <= w_phase_cnt;
      r_primed     <= r_primed | w_is_ph4;
    end else begin
      // Stall: selects hold, strobes drop.
      r_shift_en   <= 1'b0;
      r_bf_en      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_last <= 1'b0;
    end
  end

  assign o_shift_en   = r_shift_en;
  assign o_wr_sel     = r_wr_sel;
  assign o_bf_en      = r_bf_en;
  assign o_out_sel    = r_out_sel;
  assign o_tw_addr    = r_tw_addr;
  assign o_out_valid  = r_out_valid;
  assign o_frame_last = r_frame_last;
  assign o_phase      = r_phase;

  logic w_unused;
  assign w_unused = w_phase_wrap;

endmodule

// File: tb/tb_r5_sdf_ctrl.sv
// Directed self-checking bench for r5_sdf_ctrl (DEPTH=9, N_FFT=45, TW_AW=6).
module tb_r5_sdf_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_sync_clr = 1'b0;
  logic       i_in_valid = 1'b0;
  logic       o_shift_en;
  logic [1:0] o_wr_sel;
  logic       o_bf_en;
  logic [2:0] o_out_sel;
  logic [5:0] o_tw_addr;
  logic       o_out_valid;
  logic       o_frame_last;
  logic [2:0] o_phase;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  r5_sdf_ctrl #(.DEPTH(9), .N_FFT(45), .TW_AW(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_sync_clr   (i_sync_clr),
    .i_in_valid   (i_in_valid),
    .o_shift_en   (o_shift_en),
    .o_wr_sel     (o_wr_sel),
    .o_bf_en      (o_bf_en),
    .o_out_sel    (o_out_sel),
    .o_tw_addr    (o_tw_addr),
    .o_out_valid  (o_out_valid),
    .o_frame_last (o_frame_last),
    .o_phase      (o_phase)
  );

  // Drive one cycle of inputs, then sample just after the accepting edge.
  task automatic step(input logic v, input logic c);
    @(negedge clk);
    i_in_valid = v;
    i_sync_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    i_in_valid = 1'b0;
    i_sync_clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] all_out;
    #1;
    all_out = {o_shift_en, o_wr_sel, o_bf_en, o_out_sel, o_tw_addr, o_out_valid, o_frame_last, o_phase};
    n_checks++;
    if (all_out !== 16'h0) begin n_fail++; $display("FAIL reset_init outputs got %h exp 0000", all_out); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0);
    n_checks++;
    if (o_wr_sel !== 2'd1) begin n_fail++; $display("FAIL reset_pre wr_sel got %0d exp 1", o_wr_sel); end
    #1 rst = 1'b1;
    #1;
    all_out = {o_shift_en, o_wr_sel, o_bf_en, o_out_sel, o_tw_addr, o_out_valid, o_frame_last, o_phase};
    n_checks++;
    if (all_out !== 16'h0) begin n_fail++; $display("FAIL reset_async outputs got %h exp 0000", all_out); end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0);
    n_checks++;
    if ({o_shift_en, o_phase, o_wr_sel, o_out_valid} !== {1'b1, 3'd0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_first shift/phase/wr_sel/ov got %b/%0d/%0d/%b exp 1/0/0/0", o_shift_en, o_phase, o_wr_sel, o_out_valid);
    end
    for (int k = 1; k < 10; k++) step(1'b1, 1'b0);
    n_checks++;
    if (o_phase !== 3'd1) begin n_fail++; $display("FAIL reset_idx0 phase got %0d exp 1", o_phase); end
    $display("reset: done");
  endtask

  // Reference: sample k (from a clean start) has phase (k/9)%5, idx k%9.
  task automatic run_stream(input string nm, input int n_samples);
    int ph, ix;
    logic [2:0] exp_os;
    for (int k = 0; k < n_samples; k++) begin
      step(1'b1, 1'b0);
      ph = (k / 9) % 5;
      ix = k % 9;
      exp_os = (ph == 4) ? 3'd0 : 3'(ph + 1);
      $display("%s: k=%0d ph=%0d ov=%b fl=%b os=%0d tw=%0d", nm, k, o_phase, o_out_valid, o_frame_last, o_out_sel, o_tw_addr);
      n_checks++;
      if (o_phase !== 3'(ph)) begin n_fail++; $display("FAIL %s phase k=%0d got %0d exp %0d", nm, k, o_phase, ph); end
      n_checks++;
      if (o_shift_en !== 1'b1) begin n_fail++; $display("FAIL %s shift_en k=%0d got %b exp 1", nm, k, o_shift_en); end
      n_checks++;
      if (o_bf_en !== (ph == 4)) begin n_fail++; $display("FAIL %s bf_en k=%0d got %b exp %b", nm, k, o_bf_en, ph == 4); end
      n_checks++;
      if (o_wr_sel !== ((ph == 4) ? 2'd0 : 2'(ph))) begin n_fail++; $display("FAIL %s wr_sel k=%0d got %0d", nm, k, o_wr_sel); end
      n_checks++;
      if (o_out_valid !== (k >= 36)) begin n_fail++; $display("FAIL %s out_valid k=%0d got %b exp %b", nm, k, o_out_valid, k >= 36); end
      n_checks++;
      if (o_frame_last !== (ph == 4 && ix == 8)) begin n_fail++; $display("FAIL %s frame_last k=%0d got %b", nm, k, o_frame_last); end
      if (k >= 45 || ph == 4) begin
        n_checks++;
        if (o_out_sel !== exp_os) begin n_fail++; $display("FAIL %s out_sel k=%0d got %0d exp %0d", nm, k, o_out_sel, exp_os); end
        n_checks++;
        if (o_tw_addr !== 6'(exp_os * ix)) begin n_fail++; $display("FAIL %s tw_addr k=%0d got %0d exp %0d", nm, k, o_tw_addr, exp_os * ix); end
      end
      if (k == 70) begin
        n_checks++;
        if ({o_out_sel, o_tw_addr} !== {3'd3, 6'd21}) begin n_fail++; $display("FAIL %s tw_ph2_idx7 got os=%0d tw=%0d exp os=3 tw=21", nm, o_out_sel, o_tw_addr); end
      end
      if (k == 89) begin
        n_checks++;
        if ({o_out_sel, o_tw_addr} !== {3'd0, 6'd0}) begin n_fail++; $display("FAIL %s tw_ph4_idx8 got os=%0d tw=%0d exp 0/0", nm, o_out_sel, o_tw_addr); end
      end
    end
  endtask

  task automatic test_stream();
    pulse_rst();
    run_stream("stream", 90);
  endtask

  task automatic test_stall_and_sync_clr();
    pulse_rst();
    for (int k = 0; k < 60; k++) step(1'b1, 1'b0);
    n_checks++;
    if ({o_phase, o_out_sel, o_tw_addr} !== {3'd1, 3'd2, 6'd10}) begin
      n_fail++; $display("FAIL stall_pre ph/os/tw got %0d/%0d/%0d exp 1/2/10", o_phase, o_out_sel, o_tw_addr);
    end
    for (int s = 0; s < 3; s++) begin
      step(1'b0, 1'b0);
      $display("stall: cycle %0d shift=%b ov=%b", s, o_shift_en, o_out_valid);
      n_checks++;
      if ({o_shift_en, o_out_valid, o_bf_en, o_frame_last} !== 4'b0000) begin
        n_fail++; $display("FAIL stall_strobes s=%0d got %b exp 0000", s, {o_shift_en, o_out_valid, o_bf_en, o_frame_last});
      end
      n_checks++;
      if ({o_phase, o_out_sel, o_tw_addr} !== {3'd1, 3'd2, 6'd10}) begin
        n_fail++; $display("FAIL stall_hold s=%0d ph/os/tw got %0d/%0d/%0d exp 1/2/10", s, o_phase, o_out_sel, o_tw_addr);
      end
    end
    step(1'b1, 1'b0);
    n_checks++;
    if ({o_shift_en, o_out_valid, o_phase, o_tw_addr} !== {1'b1, 1'b1, 3'd1, 6'd12}) begin
      n_fail++; $display("FAIL stall_resume sh/ov/ph/tw got %b/%b/%0d/%0d exp 1/1/1/12", o_shift_en, o_out_valid, o_phase, o_tw_addr);
    end
    // Advance to phase 3 idx 6, then restart the frame.
    for (int k = 0; k < 18; k++) step(1'b1, 1'b0);
    n_checks++;
    if (o_phase !== 3'd3) begin n_fail++; $display("FAIL sclr_pre phase got %0d exp 3", o_phase); end
    step(1'b1, 1'b1);
    n_checks++;
    if ({o_shift_en, o_wr_sel, o_bf_en, o_out_sel, o_tw_addr, o_out_valid, o_frame_last, o_phase} !== 16'h0) begin
      n_fail++; $display("FAIL sclr_clear outputs got %h exp 0000", {o_shift_en, o_wr_sel, o_bf_en, o_out_sel, o_tw_addr, o_out_valid, o_frame_last, o_phase});
    end
    for (int k = 0; k < 37; k++) begin
      step(1'b1, 1'b0);
      n_checks++;
      if ({o_phase, o_out_valid} !== {3'((k / 9) % 5), k == 36}) begin
        n_fail++; $display("FAIL sclr_after k=%0d ph/ov got %0d/%b exp %0d/%b", k, o_phase, o_out_valid, (k / 9) % 5, k == 36);
      end
    end
    $display("stall/sync_clr: done");
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1);
    run_stream("wrap", 135);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall_and_sync_clr();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
